// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: the instruction word tagged with its address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; head is driven straight from storage.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push to a full FIFO unless it pops too.
import cpu_pkg::*;

module ifetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  // Storage and pointers; flush drops every entry, pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (!rst) (push && full && !flush) |-> pop);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch: issues in-order word requests, tags responses with PC, buffers them for decode.
// Latency: response to inst_valid is 1 cycle; request valid/addr are combinational from registered state.
// Backpressure: requests are credit-limited so buffered + outstanding never exceeds DEPTH; redirect blocks request and pop.
import cpu_pkg::*;

module ifetch_queue #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   redirect_tgt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              fifo_empty;
  logic              req_fire;
  logic              resp_ok;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;

  // Word alignment: the low address bits of a redirect target are forced to zero.
  assign redirect_tgt   = redirect_pc & ~XLEN'(INST_BYTES - 1);
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok        = imem_resp_valid && (outstanding != '0);
  assign push           = resp_ok && (drop_cnt == '0) && !redirect_valid;
  assign inst_valid     = !fifo_empty && !redirect_valid;
  assign pop            = inst_valid && inst_ready;
  assign {inst_pc, inst_data} = head;
  assign busy           = (outstanding != '0) || (drop_cnt != '0);

  // Fetch/response PCs and in-flight bookkeeping; a redirect marks every word still in flight as stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
        drop_cnt <= outstanding - CW'(resp_ok);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (push) begin
          resp_pc <= resp_pc + PC_STEP;
        end
        if (resp_ok && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  ifetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat ({resp_pc, imem_resp_data}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (!rst) imem_resp_valid |-> (outstanding != '0));
  assert property (@(posedge clk) disable iff (!rst) credit_used <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue with an in-order memory model and a decode-side scoreboard.
// Latency: memory answers 1..dly_max cycles after a request is accepted.
// Backpressure: decode ready and memory ready are randomized per phase.
module tb_ifetch_queue;
  import cpu_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  always #5 clk = ~clk;

  ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .busy            (busy)
  );

  // Reference model: words in flight at memory (tagged with the redirect epoch they belong to)
  // and the instructions decode should see, in order.
  typedef struct {
    logic [31:0] addr;
    int          ready_cyc;
    int          epoch;
  } req_t;

  req_t        pend[$];
  entry_t      expq[$];
  logic [31:0] m_fetch;
  int          m_epoch;
  logic        m_req_valid;
  int          cyc;

  int   p_ready, p_resp, p_irdy, p_redir, dly_max;
  logic force_redir;
  logic [31:0] force_pc;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(2))
      0:       t = $urandom & 32'h0000_0FFF;
      1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compares what the DUT presents against the model, and retires instructions decode takes.
  initial begin
    m_req_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        logic exp_rv;
        logic exp_iv;
        exp_rv = !redirect_valid && ((expq.size() + pend.size()) < DEPTH);
        m_req_valid = exp_rv;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, m_fetch);
        exp_iv = (expq.size() > 0) && !redirect_valid;
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        chk("busy", 32'(busy), 32'(pend.size() > 0));
        if (exp_iv) begin
          if (inst_valid) begin
            chk("inst_pc", inst_pc, expq[0].pc);
            chk("inst_data", inst_data, expq[0].data);
          end
          if (inst_ready) begin
            void'(expq.pop_front());
          end
        end
      end else begin
        m_req_valid = 1'b0;
      end
    end
  end

  // One clock of stimulus: drive inputs at the falling edge, then advance the model for the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    imem_req_ready = ($urandom_range(99) < p_ready);
    if (pend.size() > 0 && pend[0].ready_cyc <= cyc && $urandom_range(99) < p_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if ($urandom_range(999) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    inst_ready = ($urandom_range(99) < p_irdy);
    #3;
    if (imem_resp_valid) begin
      req_t r;
      r = pend.pop_front();
      if (!redirect_valid && r.epoch == m_epoch) begin
        expq.push_back('{pc: r.addr, data: mem_word(r.addr)});
      end
    end
    if (m_req_valid && imem_req_ready) begin
      pend.push_back('{addr: m_fetch, ready_cyc: cyc + $urandom_range(dly_max, 1), epoch: m_epoch});
      m_fetch = m_fetch + 32'd4;
    end
    if (redirect_valid) begin
      m_epoch++;
      expq.delete();
      m_fetch = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
  endtask

  task automatic set_knobs(input int rdy, input int rsp, input int irdy, input int redir, input int dly);
    p_ready = rdy; p_resp = rsp; p_irdy = irdy; p_redir = redir; dly_max = dly;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    force_redir = 1'b0; force_pc = '0;
    m_fetch = RST_PC; m_epoch = 0; cyc = 0;
    set_knobs(100, 100, 100, 0, 1);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); #2; rst = 1'b1;

    // Streaming: single-cycle memory, decode always ready.
    run(30);
    // Decode stalls: FIFO fills and requests stop, then resume one per pop.
    p_irdy = 0;   run(20);
    p_irdy = 100; run(20);

    // Three words in flight, then redirect to 0x100; stale words must be dropped.
    p_resp = 0; n = 0;
    while (pend.size() < 3 && n < 50) begin step(); n++; end
    if (pend.size() < 3) timeout_fail("three_outstanding");
    force_redir = 1'b1; force_pc = 32'h100; p_resp = 100; dly_max = 3;
    run(30);

    // Redirect landing on a response and a pending pop, then address wrap and alignment.
    dly_max = 1; run(10);
    force_redir = 1'b1; force_pc = 32'h40; run(10);
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8; run(10);
    force_redir = 1'b1; force_pc = 32'h103; run(10);

    // Randomized mixes of backpressure, latency and redirects.
    for (int k = 0; k < 6; k++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 0),
                $urandom_range(60, 0), $urandom_range(4, 1));
      run(500);
    end

    // Drain, then reach 2 buffered + 2 in flight and reset asynchronously.
    set_knobs(0, 100, 100, 0, 2); run(40);
    set_knobs(100, 0, 0, 0, 2); n = 0;
    while (pend.size() < DEPTH && n < 50) begin step(); n++; end
    p_ready = 0; p_resp = 100; n = 0;
    while (expq.size() < 2 && n < 50) begin step(); n++; end
    if (expq.size() != 2 || pend.size() != 2) timeout_fail("half_full_setup");
    @(negedge clk); #2;
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pend.delete(); expq.delete(); m_fetch = RST_PC; m_epoch = 0;
    repeat (2) @(negedge clk);
    #2; rst = 1'b1;

    // After reset only fresh words may appear.
    set_knobs(90, 80, 80, 10, 3);
    run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
